// File: rtl/nonov_seq_pkg.sv
// Shared types and helpers for the non-overlapping two-phase sequencer.
package nonov_seq_pkg;

    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned DEF_BURST_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        PH1,
        DEAD1,
        PH2,
        DEAD2
    } state_t;

    // A programmed length of zero behaves as one clock.
    function automatic int unsigned len_clamp(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/nonov_seq_cnt.sv
// Loadable down-counter shared by all timed sequencer states.
// A load of (length-1) makes expired assert on the length-th cycle.
module nonov_seq_cnt
    import nonov_seq_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    // Reload on state entry, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/nonov_phase_seq.sv
// Burst sequencer for non-overlapping two-phase clocks (ph1/ph2).
// Optional feature: define NONOV_SEQ_PERIOD_TC_EN to add the per-period
// terminal-count pulse output tc.
module nonov_phase_seq
    import nonov_seq_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               start,
    input  logic [CNT_W-1:0]   ph1_len,
    input  logic [CNT_W-1:0]   ph2_len,
    input  logic [CNT_W-1:0]   dead_len,
    input  logic [BURST_W-1:0] burst_len,
    output logic               ph1,
    output logic               ph2,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] period_cnt
`ifdef NONOV_SEQ_PERIOD_TC_EN
    ,
    output logic               tc
`endif
);

    // Counter reload value for a programmed length (clamped, minus one).
    function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] len);
        return CNT_W'(len_clamp(32'(len)) - 1);
    endfunction

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   l_ph1;
    logic [CNT_W-1:0]   l_ph2;
    logic [CNT_W-1:0]   l_dead;
    logic [BURST_W-1:0] l_burst;
    logic               stop_pend;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               expired;
    logic               accept;
    logic               period_end;
    logic               burst_end;
    logic [BURST_W:0]   pc_inc;

    assign pc_inc = {1'b0, period_cnt} + 1'b1;

    nonov_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .expired  (expired)
    );

    // Next-state, counter reload and period/burst completion decode.
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_val    = l_dead;
        accept     = 1'b0;
        period_end = 1'b0;
        burst_end  = 1'b0;
        case (state)
            IDLE: begin
                if (start && en) begin
                    accept     = 1'b1;
                    next_state = PH1;
                    cnt_load   = 1'b1;
                    cnt_val    = reload(ph1_len);
                end
            end
            PH1: begin
                if (expired) begin
                    next_state = DEAD1;
                    cnt_load   = 1'b1;
                    cnt_val    = l_dead;
                end
            end
            DEAD1: begin
                if (expired) begin
                    next_state = PH2;
                    cnt_load   = 1'b1;
                    cnt_val    = l_ph2;
                end
            end
            PH2: begin
                if (expired) begin
                    next_state = DEAD2;
                    cnt_load   = 1'b1;
                    cnt_val    = l_dead;
                end
            end
            DEAD2: begin
                if (expired) begin
                    period_end = 1'b1;
                    // en sampled low on this very edge still ends the burst here.
                    if (((l_burst != '0) && (pc_inc == {1'b0, l_burst})) ||
                        stop_pend || !en) begin
                        burst_end  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = PH1;
                        cnt_load   = 1'b1;
                        cnt_val    = l_ph1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture burst configuration on start acceptance only.
    always_ff @(posedge clk) begin
        if (reset) begin
            l_ph1   <= '0;
            l_ph2   <= '0;
            l_dead  <= '0;
            l_burst <= '0;
        end else if (accept) begin
            l_ph1   <= reload(ph1_len);
            l_ph2   <= reload(ph2_len);
            l_dead  <= reload(dead_len);
            l_burst <= burst_len;
        end
    end

    // Sticky graceful-stop request, cleared whenever the sequencer returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            stop_pend <= 1'b0;
        end else if (accept || (next_state == IDLE)) begin
            stop_pend <= 1'b0;
        end else if ((state != IDLE) && !en) begin
            stop_pend <= 1'b1;
        end
    end

    // Completed-period counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (accept) begin
            period_cnt <= '0;
        end else if (period_end && (period_cnt != '1)) begin
            period_cnt <= pc_inc[BURST_W-1:0];
        end
    end

    // Registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ph1  <= 1'b0;
            ph2  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            ph1  <= (next_state == PH1);
            ph2  <= (next_state == PH2);
            busy <= (next_state != IDLE);
            done <= burst_end;
        end
    end

`ifdef NONOV_SEQ_PERIOD_TC_EN
    // One-cycle pulse at the end of every period.
    always_ff @(posedge clk) begin
        if (reset) begin
            tc <= 1'b0;
        end else begin
            tc <= period_end;
        end
    end
`endif

endmodule

// File: tb/tb_nonov_phase_seq.sv
// Self-checking bench for nonov_phase_seq: continuous reference-model
// comparison plus table-driven bursts and directed corner sequences.
module tb_nonov_phase_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        start;
    logic [7:0]  ph1_len;
    logic [7:0]  ph2_len;
    logic [7:0]  dead_len;
    logic [15:0] burst_len;
    logic        ph1;
    logic        ph2;
    logic        busy;
    logic        done;
    logic [15:0] period_cnt;
`ifdef NONOV_SEQ_PERIOD_TC_EN
    logic        tc;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    nonov_phase_seq #(
        .CNT_W   (8),
        .BURST_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .start      (start),
        .ph1_len    (ph1_len),
        .ph2_len    (ph2_len),
        .dead_len   (dead_len),
        .burst_len  (burst_len),
        .ph1        (ph1),
        .ph2        (ph2),
        .busy       (busy),
        .done       (done),
        .period_cnt (period_cnt)
`ifdef NONOV_SEQ_PERIOD_TC_EN
        ,
        .tc         (tc)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Reference model: position inside the burst timeline, phases by offset.
    bit m_busy = 0, m_stop = 0, m_ph1 = 0, m_ph2 = 0, m_done = 0, m_tc = 0;
    int m_t = 0, m_pc = 0, mA = 1, mD = 1, mB = 1, mN = 0;

    always @(posedge clk) begin
        m_done = 0;
        m_tc   = 0;
        if (reset) begin
            m_busy = 0;
            m_stop = 0;
            m_pc   = 0;
            m_t    = 0;
        end else if (!m_busy) begin
            if (start && en) begin
                m_busy = 1;
                mA = clamp1(int'(ph1_len));
                mD = clamp1(int'(dead_len));
                mB = clamp1(int'(ph2_len));
                mN = int'(burst_len);
                m_t = 0;
                m_pc = 0;
                m_stop = 0;
            end
        end else begin
            if (!en) m_stop = 1;
            if (m_t == mA + mB + 2 * mD - 1) begin
                if (m_pc < 65535) m_pc++;
                m_tc = 1;
                if ((mN != 0 && m_pc == mN) || m_stop) begin
                    m_busy = 0;
                    m_done = 1;
                end
                m_t = 0;
            end else begin
                m_t++;
            end
        end
        m_ph1 = m_busy && (m_t < mA);
        m_ph2 = m_busy && (m_t >= mA + mD) && (m_t < mA + mD + mB);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("ph1", ph1, m_ph1);
            check("ph2", ph2, m_ph2);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("period_cnt", period_cnt, m_pc);
            check("no_overlap", ph1 & ph2, 0);
`ifdef NONOV_SEQ_PERIOD_TC_EN
            check("tc", tc, m_tc);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_lens(input int a, input int d, input int b, input int n);
        ph1_len   = 8'(a);
        dead_len  = 8'(d);
        ph2_len   = 8'(b);
        burst_len = 16'(n);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done) begin
                ok = 1;
                break;
            end
        end
    endtask

    typedef struct {
        int a, d, b, n;
        int exp_busy, exp_ph1, exp_ph2, exp_pc;
    } vec_t;

    vec_t tbl[5];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int nb, n1, n2, ntc;

        tbl[0] = '{3, 1, 2, 2, 14, 6, 4, 2};
        tbl[1] = '{0, 0, 0, 1, 4, 1, 1, 1};
        tbl[2] = '{1, 2, 3, 3, 24, 3, 9, 3};
        tbl[3] = '{5, 0, 1, 2, 16, 10, 2, 2};
        tbl[4] = '{2, 3, 0, 1, 9, 2, 1, 1};

        reset = 1; en = 0; start = 0;
        set_lens(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        tick();
        chk_on = 1;
        check("rst_ph1", ph1, 0);
        check("rst_ph2", ph2, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pc", period_cnt, 0);
        reset = 0;
        en = 1;
        tick();

        // Exact waveform of the reference two-period burst.
        set_lens(3, 1, 2, 2);
        start = 1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            start = 0;
            check("seq_ph1", ph1, ((k >= 1 && k <= 3) || (k >= 8 && k <= 10)) ? 1 : 0);
            check("seq_ph2", ph2, ((k >= 5 && k <= 6) || (k >= 12 && k <= 13)) ? 1 : 0);
            check("seq_busy", busy, (k >= 1 && k <= 14) ? 1 : 0);
            check("seq_done", done, (k == 15) ? 1 : 0);
            if (k == 15) check("seq_pc", period_cnt, 2);
        end

        // Table-driven bursts, each started in the previous done cycle.
        for (int i = 0; i < 5; i++) begin
            set_lens(tbl[i].a, tbl[i].d, tbl[i].b, tbl[i].n);
            start = 1;
            nb = 0; n1 = 0; n2 = 0; ntc = 0; ok = 0;
            for (int k = 0; k < 200; k++) begin
                tick();
                start = 0;
                nb += int'(busy);
                n1 += int'(ph1);
                n2 += int'(ph2);
`ifdef NONOV_SEQ_PERIOD_TC_EN
                ntc += int'(tc);
                if (done) check("tbl_tc_at_done", tc, 1);
`endif
                if (done) begin
                    ok = 1;
                    break;
                end
            end
            check("tbl_done_seen", ok, 1);
            check("tbl_busy_cycles", nb, tbl[i].exp_busy);
            check("tbl_ph1_cycles", n1, tbl[i].exp_ph1);
            check("tbl_ph2_cycles", n2, tbl[i].exp_ph2);
            check("tbl_pc", period_cnt, tbl[i].exp_pc);
`ifdef NONOV_SEQ_PERIOD_TC_EN
            check("tbl_tc_count", ntc, tbl[i].n);
`endif
        end
        tick();

        // Continuous mode, en dropped in the middle of PH2 of period 5.
        set_lens(2, 1, 3, 0);
        start = 1;
        tick();
        start = 0;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (period_cnt == 4 && ph2) begin
                ok = 1;
                break;
            end
        end
        check("cont_reach_p5", ok, 1);
        tick();
        en = 0;
        n2 = 1 + int'(ph2);
        for (int k = 0; k < 40; k++) begin
            tick();
            n2 += int'(ph2);
            if (done) break;
        end
        check("cont_done", done, 1);
        check("cont_pc", period_cnt, 5);
        check("cont_ph2_width", n2, 3);
        en = 1;
        tick();

        // start pulses and length changes mid-burst are ignored.
        set_lens(2, 1, 2, 2);
        start = 1;
        nb = 0;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            start = (k == 3 || k == 7) ? 1'b1 : 1'b0;
            if (k == 2) set_lens(7, 7, 7, 1);
            nb += int'(busy);
            if (done) begin
                ok = 1;
                break;
            end
        end
        start = 0;
        check("busy_ign_done", ok, 1);
        check("busy_ign_cycles", nb, 12);
        check("busy_ign_pc", period_cnt, 2);
        tick();

        // Reset during PH1.
        set_lens(4, 1, 1, 3);
        start = 1;
        tick();
        start = 0;
        tick();
        check("pre_rst_ph1", ph1, 1);
        reset = 1;
        tick();
        check("mid_rst_ph1", ph1, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pc", period_cnt, 0);
        check("mid_rst_done", done, 0);
        reset = 0;
        n1 = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n1 += int'(done) + int'(busy);
        end
        check("post_rst_quiet", n1, 0);

        // Randomized bursts with en drops, stray starts, length churn and rare resets.
        for (int it = 0; it < 300; it++) begin
            int n, rlim;
            n = int'($urandom_range(0, 4));
            rlim = int'($urandom_range(5, 60));
            set_lens(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), n);
            en = 1;
            start = 1;
            ok = 0;
            for (int k = 0; k < 200; k++) begin
                tick();
                if (k > 0 && !busy) begin
                    ok = 1;
                    break;
                end
                start = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 3) == 0)
                    set_lens(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
                en = !((n == 0 && k > rlim) || ($urandom_range(0, 59) == 0));
                reset = ($urandom_range(0, 299) == 0);
            end
            check("rand_burst_end", ok, 1);
            start = 0;
            reset = 0;
            en = 1;
            tick();
        end

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
